ram_reader: RTL
===============

RAM_READER -- requirements
Module: ram_reader

Interface
REQ-001 Parameter DEPTH, default 32: number of RAM words scanned; the address width is fixed at 5 bits.
REQ-002 Parameter DWELL, default 4: idle cycles inserted after each accepted beat; 0 means no gap.
REQ-003 Port clk, input, 1 bit: the only clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-high reset.
REQ-005 Port start, input, 1 bit: request a scan pass, sampled in IDLE only.
REQ-006 Port stop, input, 1 bit: end a continuous scan; used only when RAM_READER_CONT_EN is defined.
REQ-007 Port rd_addr, output, 5 bits: read address driven to the 32x4 RAM.
REQ-008 Port rd_data, input, 4 bits: RAM read data, valid one cycle after rd_addr is presented.
REQ-009 Port out_addr, output, 5 bits: address of the presented word.
REQ-010 Port out_data, output, 4 bits: the presented word.
REQ-011 Port out_valid, output, 1 bit: a beat is presented.
REQ-012 Port out_ready, input, 1 bit: the consumer accepts the beat.
REQ-013 Port busy, output, 1 bit: high in every state except IDLE.
REQ-014 Port done, output, 1 bit: one-cycle pulse when a pass ends.

Function
REQ-015 The FSM SHALL have exactly five states: IDLE, ISSUE, WAIT, PRESENT, DWELL.
REQ-016 IDLE with start=1 SHALL load the address counter with 0 and go to ISSUE; start outside IDLE SHALL be ignored.
REQ-017 ISSUE SHALL drive rd_addr = counter and go to WAIT unconditionally.
REQ-018 WAIT SHALL hold rd_addr, capture rd_data into out_data and the counter into out_addr at the edge, then go to PRESENT.
REQ-019 PRESENT SHALL assert out_valid and hold out_addr/out_data stable until an edge with out_valid=1 and out_ready=1.
REQ-020 On acceptance, PRESENT SHALL go to DWELL when DWELL>0, and otherwise go directly to the next-address decision.
REQ-021 DWELL SHALL count exactly DWELL cycles, then make the next-address decision.
REQ-022 Next-address decision: if counter < DEPTH-1, increment the counter and go to ISSUE; otherwise end the pass.
REQ-023 Ending a pass SHALL pulse done for one cycle, coincident with the return to IDLE.
REQ-024 Throughput SHALL be DEPTH beats per pass, in increasing address order, with no skipped or repeated address.
REQ-025 Latency from start sampled to the first out_valid SHALL be 3 cycles (IDLE->ISSUE->WAIT->PRESENT).
REQ-026 With out_ready held at 1 and DWELL=0, the beat period SHALL be 3 cycles.
REQ-027 out_ready asserted while out_valid=0 SHALL have no effect.
REQ-028 rd_addr SHALL be 0 whenever the FSM is in IDLE.

Reset
REQ-029 Asserting reset at any time, including mid-pass, SHALL immediately force IDLE and set the counters to 0.
REQ-030 Under reset, rd_addr, out_addr, out_data, out_valid, busy and done SHALL all be 0.
REQ-031 After reset deasserts, the block SHALL wait in IDLE for start; no beat is ever emitted without start.

Configuration
REQ-032 Macro RAM_READER_CONT_EN SHALL select continuous mode when defined.
REQ-033 With RAM_READER_CONT_EN defined, address DEPTH-1 SHALL wrap to 0 and the scan SHALL continue without pulsing done.
REQ-034 In continuous mode, stop=1 sampled in any busy state SHALL be latched.
REQ-035 Once stop is latched, the block SHALL end the pass (done pulse, IDLE) at the next acceptance, and the in-flight beat SHALL still be delivered.
REQ-036 Without RAM_READER_CONT_EN, the block SHALL perform a single pass, and stop SHALL be ignored.

Verification (1-cycle-latency RAM model preloaded with addr 1=0xC, addr 3=0x8, all other addresses 0x0)
REQ-037 Reset mid-pass at beat 5 -> all outputs read 0 in the same cycle; a subsequent start restarts the scan at address 0.
REQ-038 DWELL=0, out_ready=1, start for 1 cycle -> first out_valid 3 cycles later; beats (0,0x0),(1,0xC),(2,0x0),(3,0x8), ... up to address 31; 32 beats total; done pulses once; busy falls in the same cycle as the done pulse.
REQ-039 out_ready=0 for 10 cycles while beat (1,0xC) is presented -> out_valid, out_addr and out_data stay constant; the scan resumes when out_ready rises.
REQ-040 DWELL=4 -> exactly 4 cycles between each acceptance and the next ISSUE.
REQ-041 start pulsed again mid-pass -> no restart; the pass still totals 32 beats.
REQ-042 With RAM_READER_CONT_EN, run 40 beats -> beat 33 is (0,0x0); stop asserted at beat 40 -> beat 40 is delivered, then done pulses and the block returns to IDLE.

Source files
------------

// File: rtl/ram_reader_if.sv
// Bundle of the ram_reader request, RAM read port and presented-beat handshake.
// slave is the reader side; master is the controller/RAM/consumer side.
interface ram_reader_if;
    logic       start;
    logic       stop;
    logic [4:0] rd_addr;
    logic [3:0] rd_data;
    logic [4:0] out_addr;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic       busy;
    logic       done;

    modport slave (
        input  start, stop, rd_data, out_ready,
        output rd_addr, out_addr, out_data, out_valid, busy, done
    );

    modport master (
        output start, stop, rd_data, out_ready,
        input  rd_addr, out_addr, out_data, out_valid, busy, done
    );
endinterface

// File: rtl/ram_reader.sv
// Scans a 32x4 synchronous-read RAM and presents each word as a valid/ready beat.
// Define RAM_READER_CONT_EN for continuous wrap-around scanning ended by stop.
module ram_reader #(
    parameter int DEPTH = 32,
    parameter int DWELL = 4
) (
    input  logic         clk,
    input  logic         reset,
    ram_reader_if.slave  bus
);

    localparam logic [4:0] LAST_ADDR = 5'(DEPTH - 1);
    localparam int         DW_W      = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [DW_W-1:0] DW_LAST = DW_W'((DWELL > 0) ? DWELL - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_PRESENT,
        S_DWELL
    } state_t;

    state_t          r_state, w_state_nxt;
    logic [4:0]      r_cnt, w_cnt_nxt;
    logic [DW_W-1:0] r_dw_cnt, w_dw_nxt;
    logic            r_done, w_done_nxt;
    logic [4:0]      r_out_addr;
    logic [3:0]      r_out_data;
    logic            w_valid;
    logic            w_accept;
    logic            w_advance;
    logic            w_stop_req;
    logic            w_wrap;

`ifdef RAM_READER_CONT_EN
    logic r_stop;

    // A stop seen while busy is remembered until the pass closes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_stop <= 1'b0;
        end else if (w_state_nxt == S_IDLE) begin
            r_stop <= 1'b0;
        end else if (r_state != S_IDLE && bus.stop) begin
            r_stop <= 1'b1;
        end
    end

    assign w_stop_req = r_stop | bus.stop;
    assign w_wrap     = 1'b1;
`else
    logic w_unused_stop;
    assign w_unused_stop = bus.stop;
    assign w_stop_req    = 1'b0;
    assign w_wrap        = 1'b0;
`endif

    assign w_valid  = (r_state == S_PRESENT);
    assign w_accept = w_valid & bus.out_ready;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_dw_nxt    = r_dw_cnt;
        w_done_nxt  = 1'b0;
        w_advance   = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: w_state_nxt = S_WAIT;
            S_WAIT:  w_state_nxt = S_PRESENT;
            S_PRESENT: begin
                if (w_accept) begin
                    if (w_stop_req) begin
                        w_state_nxt = S_IDLE;
                        w_done_nxt  = 1'b1;
                    end else if (DWELL > 0) begin
                        w_dw_nxt    = '0;
                        w_state_nxt = S_DWELL;
                    end else begin
                        w_advance = 1'b1;
                    end
                end
            end
            S_DWELL: begin
                if (r_dw_cnt == DW_LAST) begin
                    w_advance = 1'b1;
                end else begin
                    w_dw_nxt = r_dw_cnt + 1'b1;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase

        // Next-address decision shared by the no-dwell and post-dwell paths.
        if (w_advance) begin
            if (r_cnt != LAST_ADDR) begin
                w_cnt_nxt   = r_cnt + 1'b1;
                w_state_nxt = S_ISSUE;
            end else if (w_wrap) begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_ISSUE;
            end else begin
                w_state_nxt = S_IDLE;
                w_done_nxt  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_dw_cnt   <= '0;
            r_done     <= 1'b0;
            r_out_addr <= '0;
            r_out_data <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_dw_cnt <= w_dw_nxt;
            r_done   <= w_done_nxt;
            // RAM data for the address issued last cycle is valid during WAIT.
            if (r_state == S_WAIT) begin
                r_out_addr <= r_cnt;
                r_out_data <= bus.rd_data;
            end
        end
    end

    assign bus.rd_addr   = (r_state == S_IDLE) ? 5'd0 : r_cnt;
    assign bus.out_addr  = r_out_addr;
    assign bus.out_data  = r_out_data;
    assign bus.out_valid = w_valid;
    assign bus.busy      = (r_state != S_IDLE);
    assign bus.done      = r_done;

endmodule
